regfile_read_arbiter: RTL

Shares the single 64-bit, 32:1 register-file read port among NUM_REQ requesters: decode operand A, decode operand B and the debug/scan port. It arbitrates round-robin, drives the read-mux select, and captures the mux output into a registered response. It also applies the XZR (register 31 reads as zero) rule and write-to-read bypass, so requesters never see stale data.

---
 rtl/regfile_read_arbiter_pkg.sv | 24 ++
 rtl/regfile_read_arbiter_if.sv | 34 +++
 rtl/regfile_read_arbiter_rr_pick.sv | 38 +++
 rtl/regfile_read_arbiter.sv | 88 ++++++++
 4 files changed

// File: rtl/regfile_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Register-file shared constants and types.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_W    = 64;
    localparam int ADDR_W   = 5;
    localparam logic [4:0] ZR_ADDR = 5'd31;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [63:0] reg_data_t;

    typedef enum logic [1:0] {
        SRC_RF     = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_ZERO   = 2'd2
    } data_src_e;

endpackage
`default_nettype wire

// File: rtl/regfile_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_arbiter_if
// Description : Requester, read-mux and write-port bundle for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_read_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int REG_W   = regfile_pkg::REG_W,
    parameter int ADDR_W  = regfile_pkg::ADDR_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      hold;
    logic [ADDR_W-1:0]         rd_sel;
    logic [REG_W-1:0]          rd_data;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [REG_W-1:0]          wr_data;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [REG_W-1:0]          rsp_data;

    modport slave (
        input  req_valid, req_addr, hold, rd_data, wr_en, wr_addr, wr_data,
        output req_ready, rd_sel, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_addr, hold, rd_data, wr_en, wr_addr, wr_data,
        input  req_ready, rd_sel, rsp_valid, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/regfile_read_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker starting at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 3
) (
    input  wire logic [NUM_REQ-1:0]         req,
    input  wire logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic      [NUM_REQ-1:0]         gnt,
    output logic      [$clog2(NUM_REQ)-1:0] idx,
    output logic                            any
);
    localparam int PTR_W = $clog2(NUM_REQ);

    int w_j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        w_j = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = int'(ptr) + k;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            if (!any && req[w_j]) begin
                any      = 1'b1;
                idx      = PTR_W'(w_j);
                gnt[w_j] = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_arbiter
// Description : Round-robin sharing of the register-file read port with
//               XZR and write-bypass handling and a registered response.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int REG_W   = regfile_pkg::REG_W,
    parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
    input  wire logic              clk,
    input  wire logic              reset,
    regfile_read_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [REG_W-1:0]   r_rsp_data;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic [PTR_W-1:0]   w_gidx;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic               w_any;
    logic [ADDR_W-1:0]  w_addr;
    data_src_e          w_src;
    logic [REG_W-1:0]   w_data;

    // Reset and hold both suppress grants, which keeps rd_sel/req_ready at zero.
    assign w_req = (reset || bus.hold) ? '0 : bus.req_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req (w_req),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_gidx),
        .any (w_any)
    );

    assign w_addr        = bus.req_addr[int'(w_gidx)*ADDR_W +: ADDR_W];
    assign bus.req_ready = w_gnt;
    assign bus.rd_sel    = w_any ? w_addr : '0;
    assign w_ptr_nxt     = (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + 1'b1;

    // XZR outranks bypass, so a write to register 31 is never forwarded.
    always_comb begin
        w_src = SRC_RF;
        if (w_addr == ADDR_W'(ZR_ADDR)) begin
            w_src = SRC_ZERO;
        end else if (bus.wr_en && (bus.wr_addr == w_addr)) begin
            w_src = SRC_BYPASS;
        end
    end

    always_comb begin
        w_data = bus.rd_data;
        case (w_src)
            SRC_ZERO:   w_data = '0;
            SRC_BYPASS: w_data = bus.wr_data;
            default:    w_data = bus.rd_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_gnt;
            if (w_any) begin
                r_ptr      <= w_ptr_nxt;
                r_rsp_data <= w_data;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
endmodule
`default_nettype wire
